pe_array_launch_cntl: RTL and testbench
=======================================

# pe_array_launch_cntl

Sequences streaming operations onto the PE array. It accepts one operation command at a time, carrying a PE bitmask, a tag and a timeout. It waits until every selected PE reports ready, pulses start to those PEs, collects their completion pulses, and returns a tagged status response. It sits between the stack-bus downstream command decode and the per-PE `ready`/`complete` core interface.

## Interface

Parameters:
- `NUM_PE`, default `PE_ARRAY_NUM_OF_PE` (64): number of PEs controlled.
- `TAG_WIDTH`, default 8: width of the command/response tag.
- `TMO_WIDTH`, default 16: width of the timeout count.

Ports:
- `clk`  input  1  system clock; all logic on the rising edge.
- `reset_poweron`  input  1  asynchronous, active-low reset.
- `cmd_valid`  input  1  command present.
- `cmd_ready`  output  1  command accepted when high together with `cmd_valid`.
- `cmd_pe_mask`  input  NUM_PE  PEs selected; bit i selects PE i.
- `cmd_tag`  input  TAG_WIDTH  echoed on the response.
- `cmd_timeout`  input  TMO_WIDTH  cycle budget; 0 disables the timeout.
- `pe_ready`  input  NUM_PE  per-PE ready-to-stream level.
- `pe_complete`  input  NUM_PE  per-PE one-cycle completion pulse.
- `pe_start`  output  NUM_PE  registered one-cycle start pulse.
- `rsp_valid`  output  1  response present.
- `rsp_ready`  input  1  response consumed.
- `rsp_tag`  output  TAG_WIDTH  latched `cmd_tag`.
- `rsp_status`  output  2  00 ok, 01 timeout, 10 empty mask, 11 reserved (never driven).
- `rsp_done_mask`  output  NUM_PE  PEs that completed.
- `busy`  output  1  high in every state except IDLE.

## Operation

- FSM states: IDLE, WAIT_READY, START, RUN, RESPOND.
- **IDLE:** `cmd_ready`=1.
  - On `cmd_valid`, latch mask, tag and timeout. Load the timer with `cmd_timeout`. Clear `done_mask`.
  - If the mask is 0, go to RESPOND with status 10. Otherwise go to WAIT_READY.
- **WAIT_READY:** when `(pe_ready & mask) == mask`, go to START. `pe_ready` of unselected PEs is ignored.
- **START:** `pe_start` = mask for exactly this cycle. Go to RUN. `pe_complete` sampled in START is ignored.
- **RUN:**
  - Each cycle, `done_mask |= pe_complete & mask`. Unselected completions are ignored. Repeated pulses are idempotent.
  - When the next value of `done_mask` equals mask, go to RESPOND with status 00.
- **Timer:**
  - Active in WAIT_READY, START and RUN when the latched timeout is nonzero.
  - Decrements once per cycle. If it is 1 in a cycle and the operation did not finish in that cycle, go to RESPOND with status 01. `rsp_done_mask` then shows the partial completion set.
  - Total cycles spent in WAIT_READY+START+RUN never exceed the timeout.
  - If the final completion and timer expiry land in the same cycle, completion wins and status is 00.
- **RESPOND:**
  - `rsp_valid`=1. `rsp_tag`, `rsp_status` and `rsp_done_mask` are stable until `rsp_valid && rsp_ready`. Then go to IDLE.
  - `cmd_ready`=0 here, so a command offered during the response handshake cycle is not accepted.
- **Reset (any time, including mid-operation):**
  - State returns to IDLE. Latched mask and tag clear.
  - No `pe_start` pulse is emitted, and in-flight PEs are abandoned without a response.

## Timing

- **Reset values:**
  - `cmd_ready`=1, `busy`=0, `rsp_valid`=0.
  - `pe_start`, `rsp_done_mask` and `rsp_tag` all 0; `rsp_status`=00.
- **Best-case latency:** command accepted at edge E0, all selected PEs ready.
  - WAIT_READY in cycle 1.
  - `pe_start` high in cycle 2.
  - RUN from cycle 3.
- **Completion latency:** last completion pulse sampled in cycle k gives `rsp_valid` high in cycle k+1.
- **Empty-mask command:** `rsp_valid` one cycle after acceptance.
- **Back-to-back commands:** minimum gap between a response handshake and the next command acceptance is 1 cycle (the IDLE cycle).
- **Timeout `T`:** `rsp_valid` with status 01 rises exactly T cycles after the first WAIT_READY cycle.
- **Outputs:** every output is a flop or decoded from flops only. No combinational path from inputs to outputs.

## Test plan

- **Empty mask:** reset, then cmd mask=0, tag=0x5A -> `rsp_valid` the next cycle with status 10, tag 0x5A, done_mask 0; `pe_start` never pulses.
- **Basic run:** mask=0x0000_0000_0000_0005, all PEs ready, timeout=0; pulse `pe_complete[0]` at cycle 6 and `pe_complete[2]` at cycle 9 -> `pe_start`=0x5 in cycle 2 only; `rsp_valid` in cycle 10 with status 00 and done_mask 0x5.
- **Late ready and stray completions:** mask=0x3 with `pe_ready[1]` raised at cycle 8; a `pe_complete[4]` pulse arrives mid-RUN -> start pulse in cycle 9; bit 4 is never set in done_mask.
- **Timeout:** mask=0xF, timeout=20, only PEs 0 and 1 complete -> status 01 and done_mask 0x3 with `rsp_valid` exactly 20 cycles after the first WAIT_READY cycle.
- **Completion vs. timeout tie:** the final completion arrives in the timer=1 cycle -> status 00.
- **Response backpressure and reset:** hold `rsp_ready`=0 for 15 cycles -> response fields stable and `cmd_ready`=0 throughout. Then assert `reset_poweron` low during RUN -> all outputs return to their reset values immediately, with no response emitted.

Source files
------------

// File: rtl/pe_array_launch_cntl.sv
// PE array launch controller: waits for selected PEs to be ready, pulses start,
// collects completions and returns a tagged status response.
module pe_array_launch_cntl #(
  parameter int NUM_PE    = 64,
  parameter int TAG_WIDTH = 8,
  parameter int TMO_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_poweron,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [NUM_PE-1:0]    cmd_pe_mask,
  input  logic [TAG_WIDTH-1:0] cmd_tag,
  input  logic [TMO_WIDTH-1:0] cmd_timeout,
  input  logic [NUM_PE-1:0]    pe_ready,
  input  logic [NUM_PE-1:0]    pe_complete,
  output logic [NUM_PE-1:0]    pe_start,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [TAG_WIDTH-1:0] rsp_tag,
  output logic [1:0]           rsp_status,
  output logic [NUM_PE-1:0]    rsp_done_mask,
  output logic                 busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_START,
    S_RUN,
    S_RESP
  } state_t;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_TMO   = 2'b01;
  localparam logic [1:0] ST_EMPTY = 2'b10;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [NUM_PE-1:0]      r_mask;
  logic [NUM_PE-1:0]      r_done;
  logic [NUM_PE-1:0]      r_pe_start;
  logic [TAG_WIDTH-1:0]   r_tag;
  logic [TMO_WIDTH-1:0]   r_timer;
  logic                   r_tmo_en;
  logic [1:0]             r_status;
  logic [1:0]             w_status_nxt;
  logic [NUM_PE-1:0]      w_done_nxt;
  logic                   w_accept;
  logic                   w_all_ready;
  logic                   w_all_done;
  logic                   w_expire;
  logic                   w_timing;

  assign w_accept    = cmd_valid && (r_state == S_IDLE);
  assign w_all_ready = (pe_ready & r_mask) == r_mask;
  assign w_done_nxt  = r_done | (pe_complete & r_mask);
  assign w_all_done  = w_done_nxt == r_mask;
  assign w_timing    = (r_state == S_WAIT) ||
                       (r_state == S_START) ||
                       (r_state == S_RUN);
  // Timer value 1 marks the last cycle the operation may still finish in.
  assign w_expire    = r_tmo_en && (r_timer == TMO_WIDTH'(1));

  always_comb begin
    w_state_nxt  = r_state;
    w_status_nxt = r_status;
    unique case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_pe_mask == '0) begin
            w_state_nxt  = S_RESP;
            w_status_nxt = ST_EMPTY;
          end else begin
            w_state_nxt  = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (w_expire) begin
          w_state_nxt  = S_RESP;
          w_status_nxt = ST_TMO;
        end else if (w_all_ready) begin
          w_state_nxt  = S_START;
        end
      end
      S_START: begin
        if (w_expire) begin
          w_state_nxt  = S_RESP;
          w_status_nxt = ST_TMO;
        end else begin
          w_state_nxt  = S_RUN;
        end
      end
      S_RUN: begin
        if (w_all_done) begin
          w_state_nxt  = S_RESP;
          w_status_nxt = ST_OK;
        end else if (w_expire) begin
          w_state_nxt  = S_RESP;
          w_status_nxt = ST_TMO;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      r_state    <= S_IDLE;
      r_mask     <= '0;
      r_done     <= '0;
      r_pe_start <= '0;
      r_tag      <= '0;
      r_timer    <= '0;
      r_tmo_en   <= 1'b0;
      r_status   <= ST_OK;
    end else begin
      r_state    <= w_state_nxt;
      r_status   <= w_status_nxt;
      r_pe_start <= (w_state_nxt == S_START) ? r_mask : '0;
      if (w_accept) begin
        r_mask   <= cmd_pe_mask;
        r_tag    <= cmd_tag;
        r_timer  <= cmd_timeout;
        r_tmo_en <= |cmd_timeout;
        r_done   <= '0;
      end else begin
        if (w_timing && r_tmo_en) begin
          r_timer <= r_timer - TMO_WIDTH'(1);
        end
        if (r_state == S_RUN) begin
          r_done <= w_done_nxt;
        end
      end
    end
  end

  assign cmd_ready     = (r_state == S_IDLE);
  assign busy          = (r_state != S_IDLE);
  assign rsp_valid     = (r_state == S_RESP);
  assign pe_start      = r_pe_start;
  assign rsp_tag       = r_tag;
  assign rsp_status    = r_status;
  assign rsp_done_mask = r_done;

endmodule

// File: tb/tb_pe_array_launch_cntl.sv
// Bench for pe_array_launch_cntl: directed table, reset sequence and
// randomized commands against a timeline reference model.
module tb_pe_array_launch_cntl;

  localparam int N   = 64;
  localparam int INF = 1 << 30;

  logic          clk = 1'b0;
  logic          reset_poweron = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [N-1:0]  cmd_pe_mask = '0;
  logic [7:0]    cmd_tag = '0;
  logic [15:0]   cmd_timeout = '0;
  logic [N-1:0]  pe_ready = '0;
  logic [N-1:0]  pe_complete = '0;
  logic [N-1:0]  pe_start;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [7:0]    rsp_tag;
  logic [1:0]    rsp_status;
  logic [N-1:0]  rsp_done_mask;
  logic          busy;

  pe_array_launch_cntl #(
    .NUM_PE(N),
    .TAG_WIDTH(8),
    .TMO_WIDTH(16)
  ) dut (
    .clk(clk),
    .reset_poweron(reset_poweron),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_pe_mask(cmd_pe_mask),
    .cmd_tag(cmd_tag),
    .cmd_timeout(cmd_timeout),
    .pe_ready(pe_ready),
    .pe_complete(pe_complete),
    .pe_start(pe_start),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_tag(rsp_tag),
    .rsp_status(rsp_status),
    .rsp_done_mask(rsp_done_mask),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  // Per-PE stimulus, in cycles relative to the accept cycle (cycle 0).
  int rdy_at[N];
  int p1[N];
  int p2[N];

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    logic [63:0] mask;
    logic [7:0]  tag;
    logic [15:0] tmo;
    int          late_pe;
    int          late_cyc;
    logic [63:0] cmp_a;
    int          cyc_a;
    logic [63:0] cmp_b;
    int          cyc_b;
    int          hold;
    logic [1:0]  st;
    logic [63:0] done;
    int          rsp;
    int          start;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", nm, a, e, $time);
  endtask

  task automatic drive_pe(input int c);
    for (int i = 0; i < N; i++) begin
      pe_ready[i]    = (c >= rdy_at[i]);
      pe_complete[i] = (p1[i] == c) || (p2[i] == c);
    end
  endtask

  task automatic load_vec(input vec_t v);
    for (int i = 0; i < N; i++) begin
      rdy_at[i] = (i == v.late_pe) ? v.late_cyc : 0;
      p1[i]     = v.cmp_a[i] ? v.cyc_a : -1;
      p2[i]     = v.cmp_b[i] ? v.cyc_b : -1;
    end
  endtask

  // Timeline model: ready cycle, start, earliest valid completion per PE,
  // then compare the finish cycle against the timeout window.
  function automatic void model(input logic [63:0] m, input logic [15:0] tmo,
                                output logic [1:0] st, output logic [63:0] dn,
                                output int rsp, output int start);
    int r;
    int f;
    int ci;
    int ca[N];
    if (m == '0) begin
      st = 2'b10; dn = '0; rsp = 1; start = -1;
      return;
    end
    r = 1;
    for (int i = 0; i < N; i++)
      if (m[i] && rdy_at[i] > r) r = rdy_at[i];
    f = 0;
    for (int i = 0; i < N; i++) begin
      ca[i] = INF;
      if (m[i]) begin
        ci = INF;
        if (p1[i] >= r + 2) ci = p1[i];
        if (p2[i] >= r + 2 && p2[i] < ci) ci = p2[i];
        ca[i] = ci;
        if (ci > f) f = ci;
      end
    end
    if (tmo != 0 && f > int'(tmo)) begin
      st = 2'b01;
      rsp = int'(tmo) + 1;
      start = (r + 1 <= int'(tmo)) ? r + 1 : -1;
      dn = '0;
      for (int i = 0; i < N; i++)
        if (m[i] && ca[i] <= int'(tmo)) dn[i] = 1'b1;
    end else begin
      st = 2'b00;
      rsp = f + 1;
      start = r + 1;
      dn = m;
    end
  endfunction

  // Entered between clock edges with the DUT idle; leaves it idle again
  // one cycle after the response handshake.
  task automatic run_cmd(input logic [63:0] m, input logic [7:0] tg,
                         input logic [15:0] tmo, input int hold,
                         input logic [1:0] est, input logic [63:0] edone,
                         input int ersp, input int estart);
    chk("idle cmd_ready", cmd_ready, 1);
    chk("idle busy", busy, 0);
    chk("idle rsp_valid", rsp_valid, 0);
    cmd_valid   = 1'b1;
    cmd_pe_mask = m;
    cmd_tag     = tg;
    cmd_timeout = tmo;
    rsp_ready   = 1'b0;
    drive_pe(0);
    @(posedge clk); #1;
    cmd_valid   = 1'b0;
    cmd_pe_mask = {$urandom, $urandom};
    for (int c = 1; c <= ersp + hold; c++) begin
      drive_pe(c);
      rsp_ready = (c == ersp + hold) ||
                  (c < ersp && $urandom_range(0, 1) == 1);
      cmd_valid = (c >= ersp);
      cmd_tag   = ~tg;
      @(negedge clk);
      if (c < ersp) begin
        chk("rsp_valid early", rsp_valid, 0);
        chk("busy active", busy, 1);
        chk("cmd_ready active", cmd_ready, 0);
        chk("pe_start", pe_start, (c == estart) ? m : 64'h0);
      end else begin
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_tag", rsp_tag, tg);
        chk("rsp_status", rsp_status, est);
        chk("rsp_done_mask", rsp_done_mask, edone);
        chk("cmd_ready resp", cmd_ready, 0);
        chk("pe_start resp", pe_start, 0);
      end
      @(posedge clk); #1;
    end
    cmd_valid   = 1'b0;
    rsp_ready   = 1'b0;
    pe_ready    = '0;
    pe_complete = '0;
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, " cmd_ready"}, cmd_ready, 1);
    chk({nm, " busy"}, busy, 0);
    chk({nm, " rsp_valid"}, rsp_valid, 0);
    chk({nm, " pe_start"}, pe_start, 0);
    chk({nm, " rsp_tag"}, rsp_tag, 0);
    chk({nm, " rsp_status"}, rsp_status, 0);
    chk({nm, " rsp_done_mask"}, rsp_done_mask, 0);
  endtask

  initial begin
    logic [63:0] m;
    logic [15:0] tmo;
    logic [1:0]  est;
    logic [63:0] edone;
    int          ersp;
    int          estart;
    int          r;

    tbl[0] = '{64'h0, 8'h5A, 16'd0, -1, 0, 64'h0, -1, 64'h0, -1,
               0, 2'b10, 64'h0, 1, -1};
    tbl[1] = '{64'h5, 8'h11, 16'd0, -1, 0, 64'h1, 6, 64'h4, 9,
               15, 2'b00, 64'h5, 10, 2};
    tbl[2] = '{64'h3, 8'h22, 16'd0, 1, 8, 64'h11, 12, 64'h2, 14,
               1, 2'b00, 64'h3, 15, 9};
    tbl[3] = '{64'hF, 8'h33, 16'd20, -1, 0, 64'h1, 5, 64'h2, 7,
               0, 2'b01, 64'h3, 21, 2};
    tbl[4] = '{64'h3, 8'h44, 16'd10, -1, 0, 64'h1, 4, 64'h2, 10,
               2, 2'b00, 64'h3, 11, 2};
    tbl[5] = '{64'h3, 8'h55, 16'd10, -1, 0, 64'h1, 4, 64'h2, 11,
               0, 2'b01, 64'h1, 11, 2};
    tbl[6] = '{64'h1, 8'h66, 16'd0, -1, 0, 64'h1, 2, 64'h1, 5,
               0, 2'b00, 64'h1, 6, 2};
    tbl[7] = '{64'h2, 8'h77, 16'd3, 1, 1000, 64'h2, 3, 64'h0, -1,
               0, 2'b01, 64'h0, 4, -1};
    tbl[8] = '{64'h1, 8'h88, 16'd1, -1, 0, 64'h0, -1, 64'h0, -1,
               0, 2'b01, 64'h0, 2, -1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    reset_poweron = 1'b1;

    for (int k = 0; k < 9; k++) begin
      load_vec(tbl[k]);
      run_cmd(tbl[k].mask, tbl[k].tag, tbl[k].tmo, tbl[k].hold,
              tbl[k].st, tbl[k].done, tbl[k].rsp, tbl[k].start);
    end

    // Reset during RUN: outputs drop at once, no response follows.
    for (int i = 0; i < N; i++) begin
      rdy_at[i] = 0; p1[i] = -1; p2[i] = -1;
    end
    cmd_valid = 1'b1; cmd_pe_mask = 64'h3; cmd_tag = 8'h9C;
    cmd_timeout = 16'd0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      drive_pe(c);
      @(posedge clk); #1;
    end
    chk("run busy", busy, 1);
    reset_poweron = 1'b0;
    #1;
    chk_reset_outputs("midrun reset");
    pe_complete = 64'h3;
    @(posedge clk); #1;
    @(negedge clk);
    reset_poweron = 1'b1;
    pe_complete = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("post reset rsp_valid", rsp_valid, 0);
      chk("post reset pe_start", pe_start, 0);
      chk("post reset cmd_ready", cmd_ready, 1);
    end

    for (int k = 0; k < 120; k++) begin
      m = '0;
      if ($urandom_range(0, 9) != 0)
        for (int i = 0; i < N; i++)
          if ($urandom_range(0, 15) == 0) m[i] = 1'b1;
      tmo = ($urandom_range(0, 2) == 0) ? 16'd0 :
            16'($urandom_range(1, 30));
      for (int i = 0; i < N; i++) begin
        rdy_at[i] = m[i] ? int'($urandom_range(0, 10)) :
                           int'($urandom_range(0, 60));
        p1[i] = int'($urandom_range(0, 30));
        p2[i] = int'($urandom_range(0, 45));
      end
      r = 1;
      for (int i = 0; i < N; i++)
        if (m[i] && rdy_at[i] > r) r = rdy_at[i];
      if (tmo == 0)
        for (int i = 0; i < N; i++)
          if (m[i]) p2[i] = r + 2 + int'($urandom_range(0, 15));
      model(m, tmo, est, edone, ersp, estart);
      run_cmd(m, 8'($urandom), tmo, int'($urandom_range(0, 3)),
              est, edone, ersp, estart);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
